// File: rtl/chan_reload_pkg.sv
// chan_reload_pkg: shared types and helpers for the PFB coefficient reload streamer.
//  - state_e   : reload FSM state encoding
//  - FFT_MIN/MAX : legal channel-count range (powers of two only)
//  - clog2     : constant-context ceil(log2)
//  - frame_len : fft_size -> words per reload frame (two 16-bit taps per word)
package chan_reload_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  localparam int FFT_MIN = 8;
  localparam int FFT_MAX = 2048;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Anything that is not a power of two in [FFT_MIN, FFT_MAX] loads the largest bank.
  function automatic int frame_len(input logic [11:0] fft, input int taps);
    int eff;
    eff = int'(fft);
    if (eff < FFT_MIN || eff > FFT_MAX || (eff & (eff - 1)) != 0) eff = FFT_MAX;
    return (eff * taps) / 2;
  endfunction

endpackage

// File: rtl/chan_reload_fifo.sv
// chan_reload_fifo: synchronous first-word-fall-through FIFO.
//  clk, aresetn      : clock, async active-low reset (empties the FIFO)
//  wr_en_i/wr_data_i : push (ignored when full)
//  rd_en_i           : pop the head word (ignored when empty)
//  rd_data_o         : head word, forced to zero while empty
//  empty_o, count_o  : occupancy status
module chan_reload_fifo
  import chan_reload_pkg::*;
#(
  parameter int WIDTH = 33,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       aresetn,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic                       empty_o,
  output logic [clog2(DEPTH):0]      count_o
);
  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push, pop, full;

  assign empty_o   = (count_q == '0);
  assign full      = (count_q == (AW+1)'(DEPTH));
  assign push      = wr_en_i & ~full;
  assign pop       = rd_en_i & ~empty_o;
  assign count_o   = count_q;
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

endmodule

// File: rtl/chan_reload_streamer.sv
// chan_reload_streamer: reads the PFB taps for the current fft_size out of the
// coefficient RAM and streams them as one AXIS frame (tlast on the final word).
//  clk, aresetn            : clock, async active-low reset
//  start, fft_size         : load request; fft_size != 0 updates the stored size
//  busy, done              : frame active/pending; 1-cycle pulse at frame end
//  coef_rd_en/addr/data    : coefficient RAM read port, data RD_LATENCY cycles after en
//  m_axis_reload_*         : AXIS master, tdata = {coef[2k+1], coef[2k]}
// Build option CHAN_RELOAD_AUTO_EN: a change of the stored fft_size requests a
// reload by itself (merged with any start in the same cycle).
module chan_reload_streamer
  import chan_reload_pkg::*;
#(
  parameter int TAPS_PER_PHASE = 32,
  parameter int RD_LATENCY     = 2,
  parameter int FIFO_DEPTH     = 8,
  parameter int ADDR_WIDTH     = 15
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  start,
  input  logic [11:0]           fft_size,
  output logic                  busy,
  output logic                  done,
  output logic                  coef_rd_en,
  output logic [ADDR_WIDTH-1:0] coef_rd_addr,
  input  logic [31:0]           coef_rd_data,
  output logic                  m_axis_reload_tvalid,
  output logic [31:0]           m_axis_reload_tdata,
  output logic                  m_axis_reload_tlast,
  input  logic                  m_axis_reload_tready
);
  localparam int CW = clog2(FIFO_DEPTH) + 1;
  localparam int NW = ADDR_WIDTH + 1;

  state_e                state_q;
  logic                  pending_q, done_q;
  logic [NW-1:0]         addr_q, nm1_q, frame_nm1;
  logic [11:0]           fft_size_s_q;
  logic [CW-1:0]         in_flight_q, fifo_count;
  logic [CW:0]           occ;
  logic [RD_LATENCY-1:0] vld_pipe_q, last_pipe_q;
  logic                  take, issue, last_issue, ret, fifo_empty, finish;
  logic [32:0]           fifo_rd;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)             fft_size_s_q <= 12'd128;
    else if (fft_size != '0)  fft_size_s_q <= fft_size;
  end

`ifdef CHAN_RELOAD_AUTO_EN
  logic [11:0] fft_size_p_q;
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) fft_size_p_q <= 12'd128;
    else          fft_size_p_q <= fft_size_s_q;
  end
  assign take = start | (fft_size_s_q != fft_size_p_q);
`else
  assign take = start;
`endif

  assign frame_nm1  = NW'(frame_len(fft_size_s_q, TAPS_PER_PHASE) - 1);
  // Reads in flight plus FIFO words never exceed the FIFO, so returns always fit.
  assign occ        = {1'b0, in_flight_q} + {1'b0, fifo_count};
  assign issue      = (state_q == S_READ) && (occ < (CW+1)'(FIFO_DEPTH));
  assign last_issue = (addr_q == nm1_q);
  assign ret        = vld_pipe_q[RD_LATENCY-1];
  assign finish     = fifo_empty && (in_flight_q == '0);

  assign coef_rd_en   = issue;
  assign coef_rd_addr = addr_q[ADDR_WIDTH-1:0];
  assign busy         = (state_q != S_IDLE) | pending_q;
  assign done         = done_q;

  // Read-return tracking: flags travel with each read for exactly RD_LATENCY cycles.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
      in_flight_q <= '0;
    end else begin
      vld_pipe_q[0]  <= issue;
      last_pipe_q[0] <= issue & last_issue;
      for (int k = 1; k < RD_LATENCY; k++) begin
        vld_pipe_q[k]  <= vld_pipe_q[k-1];
        last_pipe_q[k] <= last_pipe_q[k-1];
      end
      in_flight_q <= in_flight_q + CW'(issue) - CW'(ret);
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= S_IDLE;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
      addr_q    <= '0;
      nm1_q     <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (take | pending_q) begin
            state_q   <= S_READ;
            pending_q <= 1'b0;
            addr_q    <= '0;
            nm1_q     <= frame_nm1;
          end
        end
        S_READ: begin
          pending_q <= pending_q | take;
          if (issue) begin
            addr_q <= addr_q + 1'b1;
            if (last_issue) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Empty FIFO with nothing in flight means the tlast word was accepted.
          if (finish) begin
            done_q <= 1'b1;
            if (pending_q | take) begin
              state_q   <= S_READ;
              pending_q <= 1'b0;
              addr_q    <= '0;
              nm1_q     <= frame_nm1;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            pending_q <= pending_q | take;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  chan_reload_fifo #(.WIDTH(33), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .aresetn   (aresetn),
    .wr_en_i   (ret),
    .wr_data_i ({last_pipe_q[RD_LATENCY-1], coef_rd_data}),
    .rd_en_i   (m_axis_reload_tready),
    .rd_data_o (fifo_rd),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  assign m_axis_reload_tvalid = ~fifo_empty;
  assign m_axis_reload_tdata  = fifo_rd[31:0];
  assign m_axis_reload_tlast  = fifo_rd[32];

endmodule

// File: tb/tb_chan_reload_streamer.sv
module tb_chan_reload_streamer;
  localparam int TAPS = 32;
  localparam int RDL  = 2;
  localparam int FD   = 8;
  localparam int AW   = 15;
  localparam logic [31:0] K = 32'hA5A5_0000;

  logic          clk = 1'b0, aresetn = 1'b0, start = 1'b0, tready = 1'b0;
  logic [11:0]   fft_size = '0;
  logic          busy, done, coef_rd_en, tvalid, tlast;
  logic [AW-1:0] coef_rd_addr;
  logic [31:0]   coef_rd_data, tdata;

  chan_reload_streamer #(.TAPS_PER_PHASE(TAPS), .RD_LATENCY(RDL), .FIFO_DEPTH(FD), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .aresetn(aresetn), .start(start), .fft_size(fft_size),
    .busy(busy), .done(done),
    .coef_rd_en(coef_rd_en), .coef_rd_addr(coef_rd_addr), .coef_rd_data(coef_rd_data),
    .m_axis_reload_tvalid(tvalid), .m_axis_reload_tdata(tdata),
    .m_axis_reload_tlast(tlast), .m_axis_reload_tready(tready)
  );

  always #5 clk = ~clk;

  // Coefficient RAM: fixed RDL-cycle read latency, data = addr ^ K.
  logic [31:0] ram_pipe [RDL];
  always @(posedge clk) begin
    ram_pipe[0] <= coef_rd_en ? (32'(coef_rd_addr) ^ K) : 32'hDEAD_BEEF;
    for (int i = 1; i < RDL; i++) ram_pipe[i] <= ram_pipe[i-1];
  end
  assign coef_rd_data = ram_pipe[RDL-1];

  int vec = 0, err = 0;
  int word_cnt = 0, tlast_cnt = 0, done_cnt = 0;
  int wb, tlb, db;
  int rmode = 0, rcnt = 0;
  int cur = 128;
  logic [32:0] exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {12'b0, tvalid, tlast, tdata, done, busy, coef_rd_en, coef_rd_addr};
  endfunction

  // Reference frame length: legal sizes are powers of two 8..2048, else 2048.
  function automatic int model_len(input int sz);
    int eff = 2048;
    for (int p = 8; p <= 2048; p = p * 2) if (sz == p) eff = p;
    return eff * TAPS / 2;
  endfunction

  task automatic push_frame(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({(k == n - 1), 32'(k) ^ K});
  endtask

  // Output monitor / scoreboard
  logic        prev_stall = 1'b0;
  logic [32:0] prev_word;
  always @(negedge clk) begin
    if (!aresetn) prev_stall = 1'b0;
    else begin
      if (prev_stall) chk("stall_hold", {31'b0, tlast, tdata}, {31'b0, prev_word});
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          vec++; err++;
          $display("FAIL extra_word: got %0h expected none", {tlast, tdata});
        end else begin
          chk("word", {31'b0, tlast, tdata}, {31'b0, exp_q.pop_front()});
        end
        word_cnt++;
        if (tlast) tlast_cnt++;
      end
      if (done) done_cnt++;
      prev_stall = tvalid && !tready;
      prev_word  = {tlast, tdata};
    end
  end

  // tready pattern: 0 always, 1 one cycle in three, 2 random
  initial forever begin
    @(posedge clk); #1;
    case (rmode)
      0:       tready = 1'b1;
      1:       tready = (rcnt % 3 == 0);
      default: tready = 1'($urandom_range(0, 1));
    endcase
    rcnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_start();
    start = 1'b1; tick(1); start = 1'b0;
  endtask
  task automatic set_size(input int v);
    fft_size = 12'(v); tick(1); fft_size = '0;
  endtask
  task automatic snap();
    wb = word_cnt; tlb = tlast_cnt; db = done_cnt;
  endtask
  task automatic wait_frames(input int n, input int budget);
    int c = 0;
    while (done_cnt < db + n && c < budget) begin tick(1); c++; end
    if (c >= budget) begin
      vec++; err++;
      $display("FAIL timeout_done: got %0d done expected %0d", done_cnt - db, n);
    end
    tick(4);
  endtask
  task automatic wait_words(input int target, input int budget);
    int c = 0;
    while (word_cnt < target && c < budget) begin tick(1); c++; end
    if (c >= budget) begin
      vec++; err++;
      $display("FAIL timeout_words: got %0d expected %0d", word_cnt, target);
    end
  endtask

  typedef struct { int fft; int mode; int exp_words; } vec_t;
  vec_t tbl[5];

  initial begin
    tbl[0] = '{8,  0, 128};
    tbl[1] = '{16, 1, 256};
    tbl[2] = '{32, 2, 512};
    tbl[3] = '{0,  2, 512};
    tbl[4] = '{64, 1, 1024};

    // Reset state
    tick(2);
    chk("rst_outs", outs(), 64'd0);
    aresetn = 1'b1;
    tick(2);
    chk("idle_outs", outs(), 64'd0);

    // Table-driven single frames (includes first-word latency RDL+2)
    for (int i = 0; i < 5; i++) begin
      rmode = tbl[i].mode;
      if (tbl[i].fft != 0) begin set_size(tbl[i].fft); cur = tbl[i].fft; end
      push_frame(model_len(cur));
      snap();
      do_start();
      chk("lat_c1", 64'(tvalid), 64'd0);
      tick(2);
      chk("lat_c3", 64'(tvalid), 64'd0);
      tick(1);
      chk("lat_c4", 64'(tvalid), 64'd1);
      wait_frames(1, tbl[i].exp_words * 4 + 200);
      chk("tbl_words", 64'(word_cnt - wb), 64'(tbl[i].exp_words));
      chk("tbl_tlast", 64'(tlast_cnt - tlb), 64'd1);
      chk("tbl_done", 64'(done_cnt - db), 64'd1);
      chk("tbl_busy", 64'(busy), 64'd0);
      chk("tbl_queue", 64'(exp_q.size()), 64'd0);
    end

    // Starts while busy collapse into one pending frame
    rmode = 0;
    set_size(8); cur = 8;
    push_frame(128); push_frame(128);
    snap();
    do_start();
    wait_words(wb + 10, 500);
    do_start(); tick(1); do_start(); tick(2); do_start(); do_start();
    wait_frames(2, 2000);
    tick(20);
    chk("pend_words", 64'(word_cnt - wb), 64'd256);
    chk("pend_tlast", 64'(tlast_cnt - tlb), 64'd2);
    chk("pend_done", 64'(done_cnt - db), 64'd2);
    chk("pend_busy", 64'(busy), 64'd0);

    // Illegal size -> 2048 channels; size 0 keeps it
    set_size(100); cur = 100;
    push_frame(model_len(cur));
    snap();
    do_start();
    wait_frames(1, 40000);
    chk("big_words", 64'(word_cnt - wb), 64'd32768);
    chk("big_tlast", 64'(tlast_cnt - tlb), 64'd1);
    set_size(0);
    push_frame(model_len(cur));
    snap();
    do_start();
    wait_words(wb + 4096, 6000);
    chk("keep_no_tlast", 64'(tlast_cnt - tlb), 64'd0);
    chk("keep_busy", 64'(busy), 64'd1);
    aresetn = 1'b0; exp_q.delete();
    #1 chk("abort1_outs", outs(), 64'd0);
    tick(2); aresetn = 1'b1; cur = 128;

    // Reset at word 50
    rmode = 2;
    set_size(16); cur = 16;
    push_frame(256);
    snap();
    do_start();
    wait_words(wb + 50, 1000);
    aresetn = 1'b0; exp_q.delete();
    #1 chk("abort_outs", outs(), 64'd0);
    tick(3); aresetn = 1'b1; cur = 128;
    snap();
    tick(30);
    chk("post_rst_words", 64'(word_cnt - wb), 64'd0);
    chk("post_rst_outs", outs(), 64'd0);

    // fft_size change while idle
    rmode = 0;
    snap();
    set_size(256); cur = 256;
`ifdef CHAN_RELOAD_AUTO_EN
    push_frame(4096);
    wait_frames(1, 6000);
    chk("auto_words", 64'(word_cnt - wb), 64'd4096);
`else
    tick(50);
    chk("noauto_words", 64'(word_cnt - wb), 64'd0);
    chk("noauto_busy", 64'(busy), 64'd0);
`endif

    // Randomized frames with mid-frame size changes and extra starts
    rmode = 2;
    for (int r = 0; r < 6; r++) begin
      int pick, chg, extra, frames, nsz, old, total;
      pick = $urandom_range(0, 3);
      if (pick != 0) begin set_size(4 << pick); cur = 4 << pick; end
      total = model_len(cur);
      push_frame(total);
      snap();
      do_start();
      wait_words(wb + 5, 500);
      chg = $urandom_range(0, 1); extra = $urandom_range(0, 2);
      old = cur; nsz = old;
      if (chg != 0) begin
        nsz = 8 << $urandom_range(0, 1);
        fft_size = 12'(nsz); tick(1); fft_size = '0;
        cur = nsz;
      end
      for (int e = 0; e < extra; e++) begin do_start(); tick($urandom_range(0, 2)); end
      frames = (extra > 0) ? 2 : 1;
`ifdef CHAN_RELOAD_AUTO_EN
      if (chg != 0 && nsz != old) frames = 2;
`endif
      if (frames == 2) begin push_frame(model_len(cur)); total += model_len(cur); end
      wait_frames(frames, 8000);
      tick(5);
      chk("rnd_words", 64'(word_cnt - wb), 64'(total));
      chk("rnd_tlast", 64'(tlast_cnt - tlb), 64'(frames));
      chk("rnd_done", 64'(done_cnt - db), 64'(frames));
      chk("rnd_busy", 64'(busy), 64'd0);
      chk("rnd_queue", 64'(exp_q.size()), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
